// File: rtl/game_board_ctrl.sv
// rtl/game_board_ctrl.sv - N x N board controller: square ownership, turn order, legality, win/draw detection.
module game_board_ctrl #(
  parameter int N = 3,
  parameter bit FIRST_PLAYER = 1'b0,
  localparam int NN = N * N,
  localparam int IDXW = $clog2(N * N),
  localparam int CNTW = $clog2(N * N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mark_valid,
  input  logic [IDXW-1:0] mark_idx,
  output logic            ready,
  output logic            player,
  output logic [NN-1:0]   marked,
  output logic [NN-1:0]   owner,
  output logic            error,
  output logic            win,
  output logic            winner,
  output logic            draw,
  output logic [CNTW-1:0] move_count
);

  typedef enum logic [1:0] {IDLE, TURN, CHECK, OVER} state_t;

  state_t          state, state_n;
  logic            player_n, error_n, win_n, winner_n, draw_n;
  logic [NN-1:0]   marked_n, owner_n, p_mask;
  logic [CNTW-1:0] count_n;
  logic            legal;

  // True when every square of some row, column or diagonal is set in m.
  function automatic logic has_win(input logic [NN-1:0] m);
    logic any, row_ok, col_ok, dia_ok, anti_ok;
    any = 1'b0;
    dia_ok = 1'b1;
    anti_ok = 1'b1;
    for (int r = 0; r < N; r++) begin
      row_ok = 1'b1;
      col_ok = 1'b1;
      for (int c = 0; c < N; c++) begin
        row_ok = row_ok & m[r*N + c];
        col_ok = col_ok & m[c*N + r];
      end
      any = any | row_ok | col_ok;
      dia_ok = dia_ok & m[r*N + r];
      anti_ok = anti_ok & m[r*N + (N - 1 - r)];
    end
    return any | dia_ok | anti_ok;
  endfunction

  // Squares held by the player who just moved; a win needs a line fully inside it.
  assign p_mask = marked & (player ? owner : ~owner);
  assign legal  = ({1'b0, mark_idx} < NN[IDXW:0]) && !marked[mark_idx];

  always_comb begin
    state_n  = state;
    player_n = player;
    marked_n = marked;
    owner_n  = owner;
    count_n  = move_count;
    error_n  = 1'b0;
    win_n    = win;
    winner_n = winner;
    draw_n   = draw;
    if (start) begin
      state_n  = TURN;
      player_n = FIRST_PLAYER;
      marked_n = '0;
      owner_n  = '0;
      count_n  = '0;
      win_n    = 1'b0;
      winner_n = 1'b0;
      draw_n   = 1'b0;
    end else begin
      case (state)
        TURN: begin
          if (mark_valid) begin
            if (legal) begin
              marked_n[mark_idx] = 1'b1;
              owner_n[mark_idx]  = player;
              count_n            = move_count + CNTW'(1);
              state_n            = CHECK;
            end else begin
              error_n = 1'b1;
            end
          end
        end
        CHECK: begin
          if (has_win(p_mask)) begin
            win_n    = 1'b1;
            winner_n = player;
            state_n  = OVER;
          end else if (move_count == NN[CNTW-1:0]) begin
            draw_n  = 1'b1;
            state_n = OVER;
          end else begin
            player_n = ~player;
            state_n  = TURN;
          end
        end
        OVER: error_n = mark_valid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ready      <= 1'b0;
      player     <= FIRST_PLAYER;
      marked     <= '0;
      owner      <= '0;
      move_count <= '0;
      error      <= 1'b0;
      win        <= 1'b0;
      winner     <= 1'b0;
      draw       <= 1'b0;
    end else begin
      state      <= state_n;
      ready      <= (state_n == TURN);
      player     <= player_n;
      marked     <= marked_n;
      owner      <= owner_n;
      move_count <= count_n;
      error      <= error_n;
      win        <= win_n;
      winner     <= winner_n;
      draw       <= draw_n;
    end
  end

endmodule

// File: tb/tb_game_board_ctrl.sv
// tb/tb_game_board_ctrl.sv - randomized self-checking bench for game_board_ctrl (N=3).
module tb_game_board_ctrl;

  localparam int N  = 3;
  localparam int NN = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mark_valid = 1'b0;
  logic [3:0] mark_idx = '0;
  logic       ready, player, error, win, winner, draw;
  logic [8:0] marked, owner;
  logic [3:0] move_count;
  logic [27:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference game: board[i] = -1 empty, else owning player; phase 0 idle, 1 turn, 2 check, 3 over.
  int board[NN];
  int m_player, m_count, m_phase;
  bit m_err, m_win, m_winner, m_draw;

  game_board_ctrl #(.N(N), .FIRST_PLAYER(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .mark_valid(mark_valid), .mark_idx(mark_idx),
    .ready(ready), .player(player), .marked(marked), .owner(owner), .error(error),
    .win(win), .winner(winner), .draw(draw), .move_count(move_count)
  );

  always #5 clk = ~clk;

  assign dut_vec = {ready, player, marked, owner, error, win, winner, draw, move_count};

  function automatic bit line_won(int p);
    bit any = 0;
    for (int l = 0; l < 2 * N + 2; l++) begin
      int hits = 0;
      for (int k = 0; k < N; k++) begin
        int sq;
        if (l < N)           sq = l * N + k;
        else if (l < 2 * N)  sq = k * N + (l - N);
        else if (l == 2 * N) sq = k * N + k;
        else                 sq = k * N + (N - 1 - k);
        if (board[sq] == p) hits++;
      end
      if (hits == N) any = 1;
    end
    return any;
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [8:0] mk, ow;
    mk = '0;
    ow = '0;
    for (int i = 0; i < NN; i++) begin
      mk[i] = (board[i] >= 0);
      ow[i] = (board[i] == 1);
    end
    return {m_phase == 1, m_player[0], mk, ow, m_err, m_win, m_winner, m_draw, m_count[3:0]};
  endfunction

  task automatic model_reset();
    foreach (board[i]) board[i] = -1;
    m_player = 0; m_count = 0; m_phase = 0;
    m_err = 0; m_win = 0; m_winner = 0; m_draw = 0;
  endtask

  task automatic model_clock(input bit s, input bit mv, input int idx);
    m_err = 0;
    if (s) begin
      model_reset();
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (mv && idx < NN && board[idx] < 0) begin
        board[idx] = m_player;
        m_count++;
        m_phase = 2;
      end else if (mv) begin
        m_err = 1;
      end
    end else if (m_phase == 2) begin
      if (line_won(m_player)) begin
        m_win = 1; m_winner = m_player[0]; m_phase = 3;
      end else if (m_count == NN) begin
        m_draw = 1; m_phase = 3;
      end else begin
        m_player = 1 - m_player; m_phase = 1;
      end
    end else if (m_phase == 3) begin
      m_err = mv;
    end
  endtask

  task automatic step(input bit s, input bit mv, input int idx);
    @(negedge clk);
    start = s; mark_valid = mv; mark_idx = idx[3:0];
    @(posedge clk);
    model_clock(s, mv, idx);
    #1;
  endtask

  task automatic play(input int idx);
    step(0, 1, idx);
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    checks++;
    if (dut_vec !== 28'h0) begin
      errors++; $display("FAIL reset_state got %h want %h", dut_vec, 28'h0);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_idle_ignore();
    step(0, 1, 4);
    checks++;
    if (dut_vec !== exp_vec() || error !== 1'b0 || marked !== 9'h0) begin
      errors++; $display("FAIL idle_ignore got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_first_move();
    step(1, 0, 0);
    step(0, 1, 4);
    checks++;
    if (marked !== 9'h010 || owner !== 9'h0 || move_count !== 4'd1 || ready !== 1'b0) begin
      errors++; $display("FAIL first_move got m=%h o=%h c=%0d r=%b want m=010 o=000 c=1 r=0",
                         marked, owner, move_count, ready);
    end
    step(0, 0, 0);
    checks++;
    if (player !== 1'b1 || ready !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL first_move_turn got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_row_win();
    int seq[5] = '{0, 3, 1, 4, 2};
    step(1, 0, 0);
    foreach (seq[i]) play(seq[i]);
    checks++;
    if (win !== 1'b1 || winner !== 1'b0 || ready !== 1'b0 || draw !== 1'b0) begin
      errors++; $display("FAIL row_win got win=%b winner=%b ready=%b draw=%b want 1 0 0 0",
                         win, winner, ready, draw);
    end
    step(0, 1, 5);
    checks++;
    if (error !== 1'b1 || marked !== 9'h01f || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL over_error got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_repeat();
    step(1, 0, 0);
    play(4);
    step(0, 1, 4);
    checks++;
    if (error !== 1'b1 || move_count !== 4'd1 || player !== 1'b1 || owner !== 9'h0) begin
      errors++; $display("FAIL repeat_err got e=%b c=%0d p=%b o=%h want 1 1 1 000",
                         error, move_count, player, owner);
    end
    step(0, 0, 0);
    checks++;
    if (error !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL repeat_pulse got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_out_of_range();
    step(1, 0, 0);
    step(0, 1, 9);
    checks++;
    if (error !== 1'b1 || marked !== 9'h0 || ready !== 1'b1) begin
      errors++; $display("FAIL out_of_range got e=%b m=%h r=%b want 1 000 1", error, marked, ready);
    end
  endtask

  task automatic test_draw();
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    step(1, 0, 0);
    foreach (seq[i]) play(seq[i]);
    checks++;
    if (draw !== 1'b1 || win !== 1'b0 || move_count !== 4'd9 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL draw got %h want %h", dut_vec, exp_vec());
    end
    step(1, 1, 4);
    checks++;
    if (marked !== 9'h0 || player !== 1'b0 || move_count !== 4'd0 || draw !== 1'b0 ||
        error !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL restart got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    int seq[5] = '{0, 2, 1, 4, 8};
    step(1, 0, 0);
    foreach (seq[i]) play(seq[i]);
    play(6);
    checks++;
    if (win !== 1'b1 || winner !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL anti_diag_win got %h want %h", dut_vec, exp_vec());
    end
    step(1, 0, 0);
    foreach (seq[i]) play(seq[i]);
    step(0, 1, 6);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 28'h0) begin
      errors++; $display("FAIL async_reset got %h want %h", dut_vec, 28'h0);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_random();
    for (int g = 0; g < 8; g++) begin
      step(1, 0, 0);
      for (int c = 0; c < 40; c++) begin
        int q[$];
        int idx;
        bit mv, s;
        foreach (board[i]) if (board[i] < 0) q.push_back(i);
        mv = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0 || q.size() == 0) idx = $urandom_range(0, 15);
        else idx = q[$urandom_range(0, q.size() - 1)];
        s = ($urandom_range(0, 39) == 0);
        step(s, mv, idx);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL random g%0d c%0d got %h want %h", g, c, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_idle_ignore();
    test_first_move();
    test_row_win();
    test_repeat();
    test_out_of_range();
    test_draw();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
